// File: rtl/decode_prefix_sequencer.sv
// decode_prefix_sequencer: prefix-decode stage sequencer.
// Consumes one fetch byte per cycle and counts prefix bytes. On the opcode byte it
// checks the total instruction length against MAX_LEN, then either issues the
// instruction to the decoder or raises a length fault.
// Optional feature: define DECODE_PREFIX_STATS_EN to add the stat_prefixed counter port.
module decode_prefix_sequencer #(
  parameter int unsigned MAX_LEN = 15,
  parameter int unsigned CNT_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_valid,
  input  logic [7:0]       fetch_byte,
  input  logic [CNT_W-1:0] opcode_len,
  output logic             fetch_accept,
  output logic             instr_prefix,
  output logic             instr_finished,
  output logic [CNT_W-1:0] prefix_count,
  output logic             dec_valid,
  output logic [CNT_W-1:0] dec_len,
  input  logic             dec_ready,
  output logic             fault_len,
  input  logic             fault_ack,
  input  logic             flush
`ifdef DECODE_PREFIX_STATS_EN
  ,
  output logic [31:0]      stat_prefixed
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_FAULT} state_e;

  localparam logic [CNT_W-1:0] MAX_CNT = MAX_LEN[CNT_W-1:0];
  localparam logic [CNT_W:0]   MAX_SUM = MAX_LEN[CNT_W:0];

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic             is_prefix;
  logic [CNT_W:0]   sum;

  // Classify the head byte as a legacy/REX-less prefix or escape byte.
  always_comb begin
    is_prefix = 1'b0;
    case (fetch_byte)
      8'hF2, 8'hF3, 8'hF0, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'h64, 8'h65, 8'h66, 8'h67, 8'h0F: is_prefix = 1'b1;
      default:                           is_prefix = 1'b0;
    endcase
  end

  assign sum = {1'b0, cnt_q} + {1'b0, opcode_len};

  // Next-state and strobe logic; flush outranks handshakes, which outrank fetch.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    len_d          = len_q;
    fetch_accept   = 1'b0;
    instr_prefix   = 1'b0;
    instr_finished = 1'b0;
    if (rst) begin
      // Combinational strobes stay quiet while reset is asserted.
      state_d = state_q;
    end else if (flush) begin
      instr_finished = 1'b1;
      cnt_d          = '0;
      state_d        = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (fetch_valid) begin
            if (is_prefix) begin
              if (cnt_q < MAX_CNT) begin
                fetch_accept = 1'b1;
                instr_prefix = 1'b1;
                cnt_d        = cnt_q + 1'b1;
              end else begin
                state_d = S_FAULT;
              end
            end else if (sum > MAX_SUM) begin
              state_d = S_FAULT;
            end else begin
              fetch_accept = 1'b1;
              len_d        = sum[CNT_W-1:0];
              state_d      = S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (dec_ready) begin
            instr_finished = 1'b1;
            cnt_d          = '0;
            state_d        = S_IDLE;
          end
        end
        S_FAULT: begin
          if (fault_ack) begin
            instr_finished = 1'b1;
            cnt_d          = '0;
            state_d        = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, prefix count and issued length registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign prefix_count = cnt_q;
  assign dec_len      = len_q;
  assign dec_valid    = (state_q == S_ISSUE);
  assign fault_len    = (state_q == S_FAULT);

`ifdef DECODE_PREFIX_STATS_EN
  logic [31:0] stat_q;

  // Count completed decoder handshakes of instructions that carried prefixes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_q <= '0;
    end else if (!flush && (state_q == S_ISSUE) && dec_ready && (cnt_q != '0)) begin
      stat_q <= stat_q + 32'd1;
    end
  end

  assign stat_prefixed = stat_q;
`endif

endmodule
